flow_pattern_monitor: RTL



---
 rtl/flow_pattern_monitor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/flow_pattern_monitor.sv
// Receive-side checker for a rotating one-cold LED pattern: decodes the dark LED,
// locks onto the rotation direction, counts revolutions and flags pattern errors.
module flow_pattern_monitor #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned PW        = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic [DATA_WIDTH-1:0] led_in,
  input  logic                  clear,
  output logic [PW-1:0]         pos,
  output logic                  pos_valid,
  output logic                  dir,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  rot_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_sticky
);

  localparam logic [0:0] StHunt   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  localparam logic [PW-1:0] IdxMax  = PW'(DATA_WIDTH - 1);
  localparam logic [3:0]    LockCnt = 4'(LOCK_COUNT);

  logic [0:0]           state_q, state_d;
  logic [3:0]           match_q, match_d;
  logic                 cand_q, cand_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [PW-1:0]        prev_idx_q, prev_idx_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic                 pos_valid_q, pos_valid_d;
  logic                 dir_q, dir_d;
  logic [CNT_WIDTH-1:0] rot_q, rot_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic                 sticky_q, sticky_d;

  logic [DATA_WIDTH-1:0] cold;
  logic [PW:0]           ones;
  logic [PW-1:0]         idx;
  logic                  valid;
  logic [PW-1:0]         prev_dn, prev_up;
  logic                  step_ok, is_stall, is_dn, is_up, is_jump, wrap, dir_step;
  logic                  rot_inc, err_inc;

  always_comb begin
    cold = ~led_in;
    ones = '0;
    idx  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (cold[i]) begin
        ones = ones + 1'b1;
        idx  = PW'(i);
      end
    end
    valid = (ones == (PW + 1)'(1));
  end

  // Neighbour indices modulo DATA_WIDTH, which need not be a power of two.
  assign prev_dn  = (prev_idx_q == '0) ? IdxMax : prev_idx_q - 1'b1;
  assign prev_up  = (prev_idx_q == IdxMax) ? '0 : prev_idx_q + 1'b1;
  assign step_ok  = valid && prev_valid_q;
  assign is_stall = step_ok && (idx == prev_idx_q);
  assign is_dn    = step_ok && (idx == prev_dn);
  assign is_up    = step_ok && (idx == prev_up);
  assign is_jump  = step_ok && !is_stall && !is_dn && !is_up;
  assign dir_step = dir_q ? is_up : is_dn;
  assign wrap     = dir_q ? (prev_idx_q == IdxMax) : (prev_idx_q == '0);

  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    cand_d       = cand_q;
    prev_valid_d = prev_valid_q;
    prev_idx_d   = prev_idx_q;
    pos_d        = pos_q;
    pos_valid_d  = pos_valid_q;
    dir_d        = dir_q;
    rot_inc      = 1'b0;
    err_inc      = 1'b0;

    if (sample_en) begin
      prev_valid_d = valid;
      pos_valid_d  = valid;
      if (valid) begin
        prev_idx_d = idx;
        pos_d      = idx;
      end
      case (state_q)
        StHunt: begin
          if (!valid || is_jump) begin
            match_d = '0;
          end else if (is_up || is_dn) begin
            if (match_q == '0 || is_up != cand_q) begin
              cand_d  = is_up;
              match_d = 4'd1;
            end else begin
              match_d = match_q + 4'd1;
            end
            if (match_d == LockCnt) begin
              state_d = StLocked;
              dir_d   = cand_d;
            end
          end
        end
        StLocked: begin
          if (is_stall) begin
            state_d = StLocked;
          end else if (dir_step) begin
            rot_inc = wrap;
          end else begin
            err_inc = 1'b1;
            state_d = StHunt;
            match_d = '0;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // clear wins over any increment landing in the same cycle.
  always_comb begin
    rot_d    = rot_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    if (clear) begin
      rot_d    = '0;
      err_d    = '0;
      sticky_d = 1'b0;
    end else begin
      if (rot_inc && rot_q != '1) rot_d = rot_q + 1'b1;
      if (err_inc && err_q != '1) err_d = err_q + 1'b1;
      if (err_inc) sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StHunt;
      match_q      <= '0;
      cand_q       <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_idx_q   <= '0;
      pos_q        <= '0;
      pos_valid_q  <= 1'b0;
      dir_q        <= 1'b0;
      rot_q        <= '0;
      err_q        <= '0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      cand_q       <= cand_d;
      prev_valid_q <= prev_valid_d;
      prev_idx_q   <= prev_idx_d;
      pos_q        <= pos_d;
      pos_valid_q  <= pos_valid_d;
      dir_q        <= dir_d;
      rot_q        <= rot_d;
      err_q        <= err_d;
      sticky_q     <= sticky_d;
    end
  end

  assign pos        = pos_q;
  assign pos_valid  = pos_valid_q;
  assign dir        = dir_q;
  assign locked     = (state_q == StLocked);
  assign rot_count  = rot_q;
  assign err_count  = err_q;
  assign err_sticky = sticky_q;

endmodule
